// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM filled by a byte-stream loader; holds the core in reset until a well-formed image is loaded
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              reload_i,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [7:0]        chk_o
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;
  state_t state, state_nx;
  logic [31:0] mem [2**ADDR_W];
  logic [1:0] idx;
  logic [23:0] acc;
  logic accept, word_done, full, hit;
  logic [ADDR_W-1:0] rd_idx;
  // a reload in the same cycle wins over the byte, so the byte is never accepted
  assign accept = ld_valid_i && ld_ready_o && !reload_i;
  assign word_done = accept && idx == 2'd3;
  assign full = word_count_o[ADDR_W];
  assign ld_ready_o = state == LOAD;
  assign cpu_rst_o = state != RUN;
  assign load_done_o = state == RUN;
  assign load_err_o = state == ERR;
  assign rd_idx = rom_addr_i[ADDR_W+1:2];
  // unwritten words stay masked by the word count, so the array never needs clearing
  assign hit = rom_ce_i && state == RUN && rom_addr_i[31:ADDR_W+2] == '0 && {1'b0, rd_idx} < word_count_o;
  assign rom_data_o = hit ? mem[rd_idx] : '0;
  // next state: last byte must close a word, and a word beyond the array is an error
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = LOAD;
      LOAD: if (accept && (ld_last_i || (word_done && full))) state_nx = (word_done && !full) ? RUN : ERR;
      default: if (reload_i) state_nx = IDLE;
    endcase
  end
  // state register, byte assembly, word counter and running checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      acc <= '0;
      word_count_o <= '0;
      chk_o <= '0;
    end else begin
      state <= state_nx;
      if (reload_i) begin
        idx <= '0;
        word_count_o <= '0;
        chk_o <= '0;
      end else if (accept) begin
        idx <= idx + 2'd1;
        acc <= {acc[15:0], ld_byte_i};
        chk_o <= chk_o + ld_byte_i;
        if (word_done && !full) word_count_o <= word_count_o + (ADDR_W+1)'(1);
      end
    end
  end
  // big-endian word write on the fourth byte; an overflowing word is dropped
  always_ff @(posedge clk) begin
    if (word_done && !full) mem[word_count_o[ADDR_W-1:0]] <= {acc, ld_byte_i};
  end
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: randomized bench with a byte-image reference model for two array depths
module tb_inst_rom_loader;
  logic clk = 0, rst = 0, rom_ce = 0, ld_valid = 0, ld_last = 0, reload = 0;
  logic [31:0] rom_addr = 0;
  logic [7:0] ld_byte = 0;
  logic [31:0] data0, data1;
  logic rdy0, rdy1, crst0, crst1, done0, done1, err0, err1;
  logic [10:0] wc0;
  logic [2:0] wc1;
  logic [7:0] chk0, chk1;
  int total = 0, bad = 0;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_ERR = 3;
  int mode [2];
  int nb [2];
  logic [7:0] msum [2];
  logic [7:0] img [2][8192];

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) u0 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data0),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last), .ld_ready_o(rdy0),
    .reload_i(reload), .cpu_rst_o(crst0), .load_done_o(done0), .load_err_o(err0),
    .word_count_o(wc0), .chk_o(chk0)
  );
  inst_rom_loader #(.ADDR_W(2)) u1 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data1),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last), .ld_ready_o(rdy1),
    .reload_i(reload), .cpu_rst_o(crst1), .load_done_o(done1), .load_err_o(err1),
    .word_count_o(wc1), .chk_o(chk1)
  );

  function automatic int depth(int k);
    return k == 0 ? 1024 : 4;
  endfunction

  function automatic int mwc(int k);
    return nb[k] / 4 < depth(k) ? nb[k] / 4 : depth(k);
  endfunction

  function automatic logic [31:0] mrd(int k);
    logic [31:0] w;
    int i;
    w = rom_addr >> 2;
    if (rom_ce && mode[k] == M_RUN && w < 32'(mwc(k))) begin
      i = int'(w) * 4;
      return {img[k][i], img[k][i+1], img[k][i+2], img[k][i+3]};
    end
    return 32'h0;
  endfunction

  // reference model: the image is the list of accepted bytes, words and counts derive from it
  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mode[k] = M_IDLE;
        nb[k] = 0;
        msum[k] = 0;
      end else if (reload) begin
        mode[k] = (mode[k] == M_RUN || mode[k] == M_ERR) ? M_IDLE : M_LOAD;
        nb[k] = 0;
        msum[k] = 0;
      end else if (mode[k] == M_IDLE) begin
        mode[k] = M_LOAD;
      end else if (mode[k] == M_LOAD && ld_valid) begin
        if (nb[k] < 8192) img[k][nb[k]] = ld_byte;
        nb[k]++;
        msum[k] = msum[k] + ld_byte;
        if (nb[k] % 4 == 0 && nb[k] / 4 > depth(k)) mode[k] = M_ERR;
        else if (ld_last) mode[k] = (nb[k] % 4 == 0) ? M_RUN : M_ERR;
      end
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare every output of both instances against the model each cycle
  always @(negedge clk) begin
    check("u0 ready", 32'(rdy0), 32'(mode[0] == M_LOAD));
    check("u0 cpu_rst", 32'(crst0), 32'(mode[0] != M_RUN));
    check("u0 done", 32'(done0), 32'(mode[0] == M_RUN));
    check("u0 err", 32'(err0), 32'(mode[0] == M_ERR));
    check("u0 wcount", 32'(wc0), 32'(mwc(0)));
    check("u0 chk", 32'(chk0), 32'(msum[0]));
    check("u0 data", data0, mrd(0));
    check("u1 ready", 32'(rdy1), 32'(mode[1] == M_LOAD));
    check("u1 cpu_rst", 32'(crst1), 32'(mode[1] != M_RUN));
    check("u1 done", 32'(done1), 32'(mode[1] == M_RUN));
    check("u1 err", 32'(err1), 32'(mode[1] == M_ERR));
    check("u1 wcount", 32'(wc1), 32'(mwc(1)));
    check("u1 chk", 32'(chk1), 32'(msum[1]));
    check("u1 data", data1, mrd(1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] b, logic last);
    ld_valid = 1;
    ld_byte = b;
    ld_last = last;
    tick();
    ld_valid = 0;
    ld_last = 0;
  endtask

  task automatic send_rand(logic [7:0] b, logic last);
    while ($urandom_range(0, 2) == 0) begin
      ld_valid = 0;
      ld_byte = 8'($urandom);
      ld_last = 1'($urandom);
      tick();
    end
    send(b, last);
  endtask

  task automatic rd(string n, logic ce, logic [31:0] a, logic [31:0] e);
    rom_ce = ce;
    rom_addr = a;
    #1;
    check(n, data0, e);
    tick();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, " ready"}, 32'(rdy0), 0);
    check({tag, " cpu_rst"}, 32'(crst0), 1);
    check({tag, " done"}, 32'(done0), 0);
    check({tag, " err"}, 32'(err0), 0);
    check({tag, " wcount"}, 32'(wc0), 0);
    check({tag, " chk"}, 32'(chk0), 0);
    check({tag, " data"}, data0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog [8];
    logic [7:0] bs [12];
    logic [7:0] sum;
    prog = '{8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h02, 8'h00, 8'h20};
    rom_ce = 1;
    repeat (2) @(posedge clk);
    #2;
    check_reset_vals("reset");
    rst = 1;
    tick();
    check("release ready", 32'(rdy0), 1);
    check("release cpu_rst", 32'(crst0), 1);
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    check("prog wcount", 32'(wc0), 2);
    check("prog chk", 32'(chk0), 32'h9C);
    check("prog cpu_rst", 32'(crst0), 0);
    check("prog done", 32'(done0), 1);
    check("prog ready", 32'(rdy0), 0);
    rd("fetch 0", 1, 32'h0, 32'h34011100);
    rd("fetch 4", 1, 32'h4, 32'h34020020);
    rd("fetch 7", 1, 32'h7, 32'h34020020);
    rd("fetch 8", 1, 32'h8, 32'h0);
    rd("fetch ce0", 0, 32'h0, 32'h0);
    rd("fetch 1000", 1, 32'h1000, 32'h0);
    ld_valid = 1;
    ld_byte = 8'hAA;
    rom_addr = 0;
    reload = 1;
    tick();
    reload = 0;
    ld_valid = 0;
    check("reload cpu_rst", 32'(crst0), 1);
    check("reload wcount", 32'(wc0), 0);
    check("reload chk", 32'(chk0), 0);
    check("reload masked", data0, 0);
    tick();
    check("reload ready", 32'(rdy0), 1);
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6);
    check("partial err", 32'(err0), 1);
    check("partial cpu_rst", 32'(crst0), 1);
    check("partial ready", 32'(rdy0), 0);
    check("partial chk", 32'(chk0), 32'h15);
    reload = 1;
    tick();
    reload = 0;
    check("err reload err", 32'(err0), 0);
    check("err reload idle ready", 32'(rdy0), 0);
    check("err reload wcount", 32'(wc0), 0);
    tick();
    check("err reload load", 32'(rdy0), 1);
    for (int i = 1; i <= 20; i++) send(8'(i), 0);
    check("ovf err", 32'(err1), 1);
    check("ovf wcount", 32'(wc1), 4);
    check("ovf ready", 32'(rdy1), 0);
    check("ovf chk", 32'(chk1), 32'hD2);
    check("big no err", 32'(err0), 0);
    check("big wcount", 32'(wc0), 5);
    reload = 1;
    tick();
    reload = 0;
    tick();
    for (int i = 0; i < 6; i++) send_rand(8'($urandom), 0);
    #2 rst = 0;
    #1;
    check_reset_vals("async");
    check("async u1 ready", 32'(rdy1), 0);
    @(posedge clk);
    #3 rst = 1;
    tick();
    sum = 0;
    for (int i = 0; i < 12; i++) begin
      bs[i] = 8'($urandom);
      sum = sum + bs[i];
      send_rand(bs[i], i == 11);
    end
    check("img3 done", 32'(done0), 1);
    check("img3 wcount", 32'(wc0), 3);
    check("img3 chk", 32'(chk0), 32'(sum));
    for (int w = 0; w < 3; w++)
      rd("img3 fetch", 1, 32'(w * 4), {bs[4*w], bs[4*w+1], bs[4*w+2], bs[4*w+3]});
    for (int c = 0; c < 3000; c++) begin
      ld_valid = 1'($urandom);
      ld_byte = 8'($urandom);
      ld_last = $urandom_range(0, 7) == 0;
      reload = $urandom_range(0, 39) == 0;
      rom_ce = 1'($urandom);
      rom_addr = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 0;
        #1 rst = 1;
      end
      tick();
    end
    ld_valid = 0;
    ld_last = 0;
    reload = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
